// File: rtl/lsu_dmem.sv
// Load/store unit between the core data port and a single-port, variable-latency data memory.
// One request at a time; misaligned, illegal-width and timed-out accesses return an error response.
module lsu_dmem #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0]  StIdle     = 2'd0;
  localparam logic [1:0]  StBusy     = 2'd1;
  localparam logic [1:0]  StResp     = 2'd2;
  localparam logic [15:0] TimeoutVal = TIMEOUT_CYCLES[15:0];

  logic [1:0]  r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic        r_we, w_we_d;
  logic [2:0]  r_funct3, w_funct3_d;
  logic [1:0]  r_addr_lo, w_addr_lo_d;
  logic        r_rd, w_rd_d;
  logic        r_wr, w_wr_d;
  logic [31:0] r_mem_addr, w_mem_addr_d;
  logic [31:0] r_mem_wdata, w_mem_wdata_d;
  logic [3:0]  r_mem_be, w_mem_be_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic        r_err, w_err_d;

  logic        w_illegal;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [15:0] w_cnt_inc;

  // Decode of the request presented at the port (only consumed in IDLE).
  always_comb begin
    if (req_we_i) begin
      w_illegal = (req_funct3_i >= 3'b011);
    end else begin
      w_illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    end
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_misaligned = req_addr_i[0];
        w_be         = req_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{req_wdata_i[15:0]}};
      end
      default: w_misaligned = (req_addr_i[1:0] != 2'b00);
    endcase
  end

  assign w_shifted = mem_rdata_i >> {r_addr_lo, 3'b000};
  assign w_cnt_inc = r_cnt + 16'd1;

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_we_d        = r_we;
    w_funct3_d    = r_funct3;
    w_addr_lo_d   = r_addr_lo;
    w_rd_d        = r_rd;
    w_wr_d        = r_wr;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_mem_be_d    = r_mem_be;
    w_rdata_d     = r_rdata;
    w_err_d       = r_err;
    case (r_state)
      StIdle: begin
        if (req_valid_i) begin
          w_we_d      = req_we_i;
          w_funct3_d  = req_funct3_i;
          w_addr_lo_d = req_addr_i[1:0];
          if (w_illegal || w_misaligned) begin
            w_state_d = StResp;
            w_err_d   = 1'b1;
            w_rdata_d = 32'd0;
          end else begin
            w_state_d     = StBusy;
            w_cnt_d       = 16'd0;
            w_mem_addr_d  = {req_addr_i[31:2], 2'b00};
            w_mem_be_d    = w_be;
            w_mem_wdata_d = w_wdata;
            w_rd_d        = ~req_we_i;
            w_wr_d        = req_we_i;
          end
        end
      end
      StBusy: begin
        w_cnt_d = w_cnt_inc;
        // Ack takes priority over a timeout expiring in the same cycle.
        if (mem_ack_i) begin
          w_state_d = StResp;
          w_rd_d    = 1'b0;
          w_wr_d    = 1'b0;
          w_err_d   = 1'b0;
          w_rdata_d = r_we ? 32'd0 : w_load_data;
        end else if (w_cnt_inc == TimeoutVal) begin
          w_state_d = StResp;
          w_rd_d    = 1'b0;
          w_wr_d    = 1'b0;
          w_err_d   = 1'b1;
          w_rdata_d = 32'd0;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= StIdle;
      r_cnt       <= 16'd0;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_we        <= w_we_d;
      r_funct3    <= w_funct3_d;
      r_addr_lo   <= w_addr_lo_d;
      r_rd        <= w_rd_d;
      r_wr        <= w_wr_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_mem_be    <= w_mem_be_d;
      r_rdata     <= w_rdata_d;
      r_err       <= w_err_d;
    end
  end

  assign req_ready_o = (r_state == StIdle);
  assign rsp_valid_o = (r_state == StResp);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_be_o    = r_mem_be;
  assign mem_rd_o    = r_rd;
  assign mem_wr_o    = r_wr;

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: directed cases plus randomized traffic, all checked every cycle against a
// transaction-level model of the load/store unit kept in the bench.
module tb_lsu_dmem;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_f3 = 3'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  lsu_dmem #(
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_funct3_i(req_f3),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference rules ----------------
  function automatic bit legal(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit aligned(input logic [31:0] addr, input logic [2:0] f3);
    return (int'(addr[1:0]) % size_of(f3)) == 0;
  endfunction

  function automatic logic [3:0] be_of(input logic [31:0] addr, input logic [2:0] f3);
    logic [3:0] be;
    int a;
    a = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + size_of(f3));
    return be;
  endfunction

  function automatic logic [31:0] wlanes(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % size_of(f3)) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic [7:0]         lanes [4];
    logic signed [31:0] s;
    int                 idx;
    idx = int'(lo);
    for (int i = 0; i < 4; i++) lanes[i] = word[8*i +: 8];
    case (f3)
      3'd0: begin s = $signed(lanes[idx]); return s; end
      3'd1: begin s = $signed({lanes[(idx+1)%4], lanes[idx]}); return s; end
      3'd4: return {24'd0, lanes[idx]};
      3'd5: return {16'd0, lanes[(idx+1)%4], lanes[idx]};
      default: return word;
    endcase
  endfunction

  // ---------------- model state ----------------
  bit          m_txn = 0, m_resp = 0, m_accepted = 0;
  bit          m_we = 0;
  logic [2:0]  m_f3 = 3'd0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
  int          m_age = 0, m_lat = 0;
  logic [31:0] exp_rdata = 32'd0;
  bit          exp_err = 0;
  int          drv_lat = 1;
  bit          fixed_rd = 0, stray_en = 0;
  logic [31:0] seen_addr = 32'd0, seen_wdata = 32'd0;
  logic [3:0]  seen_be = 4'd0;

  // Model update at each rising edge, then compare the DUT outputs for the new cycle.
  initial forever begin
    @(posedge clk);
    m_accepted = 0;
    if (!rst_n) begin
      m_txn = 0; m_resp = 0; exp_rdata = 32'd0; exp_err = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_txn) begin
      m_age++;
      if (mem_ack) begin
        m_txn = 0; m_resp = 1; exp_err = 0;
        exp_rdata = m_we ? 32'd0 : load_ext(mem_rdata, m_f3, m_addr[1:0]);
      end else if (m_age == int'(TO)) begin
        m_txn = 0; m_resp = 1; exp_err = 1; exp_rdata = 32'd0;
      end
    end else if (req_valid) begin
      m_accepted = 1;
      m_we = req_we; m_f3 = req_f3; m_addr = req_addr; m_wdata = req_wdata;
      if (!legal(m_we, m_f3) || !aligned(m_addr, m_f3)) begin
        m_resp = 1; exp_err = 1; exp_rdata = 32'd0;
      end else begin
        m_txn = 1; m_age = 0; m_lat = drv_lat;
      end
    end
    #1;
    check("req_ready", req_ready, !(m_txn || m_resp));
    check("mem_rd", mem_rd, m_txn && !m_we);
    check("mem_wr", mem_wr, m_txn && m_we);
    check("rsp_valid", rsp_valid, m_resp);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, exp_err);
    if (m_txn) begin
      check("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
      check("mem_be", mem_be, be_of(m_addr, m_f3));
      if (m_we) check("mem_wdata", mem_wdata, wlanes(m_wdata, m_f3));
    end
    if (mem_rd || mem_wr) begin
      seen_addr = mem_addr; seen_be = mem_be; seen_wdata = mem_wdata;
    end
  end

  // Memory responder: ack on the chosen BUSY cycle, optional stray acks while idle.
  initial forever begin
    @(negedge clk);
    mem_rdata = fixed_rd ? 32'h80FF_7F01 : $urandom;
    if (m_txn) mem_ack = (m_age + 1 == m_lat);
    else       mem_ack = stray_en && ($urandom_range(0, 3) == 0);
  end

  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat);
    bit ok;
    @(negedge clk);
    req_valid = 1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd; drv_lat = lat;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = m_accepted;
    end
    req_valid = 0;
    if (!ok) begin n_checks++; $display("FAIL accept_wait: got none expected acceptance"); end
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (!m_txn && !m_resp) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin n_checks++; $display("FAIL done_wait: got busy expected idle"); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Hand-computed values pinning the reference rules.
    check("pin_lb", load_ext(32'h80FF_7F01, 3'd0, 2'd2), 32'hFFFF_FFFF);
    check("pin_lbu", load_ext(32'h80FF_7F01, 3'd4, 2'd2), 32'h0000_00FF);
    check("pin_lh", load_ext(32'h80FF_7F01, 3'd1, 2'd2), 32'hFFFF_80FF);
    check("pin_be_sb", {28'd0, be_of(32'h1003, 3'd0)}, 32'h8);
    check("pin_wd_sb", wlanes(32'h1234_56AB, 3'd0), 32'hABAB_ABAB);
    check("pin_lw_mis", {31'd0, aligned(32'h102, 3'd2)}, 32'd0);

    run_req(1, 3'd0, 32'h0000_1003, 32'h1234_56AB, 2);
    check("sb_addr", seen_addr, 32'h0000_1000);
    check("sb_be", {28'd0, seen_be}, 32'h8);
    check("sb_wdata", seen_wdata, 32'hABAB_ABAB);
    check("sb_err", {31'd0, rsp_err}, 32'd0);

    fixed_rd = 1;
    run_req(0, 3'd0, 32'h0000_0102, 32'd0, 1);
    check("lb_rdata", rsp_rdata, 32'hFFFF_FFFF);
    run_req(0, 3'd4, 32'h0000_0102, 32'd0, 3);
    check("lbu_rdata", rsp_rdata, 32'h0000_00FF);
    run_req(0, 3'd1, 32'h0000_0102, 32'd0, 2);
    check("lh_rdata", rsp_rdata, 32'hFFFF_80FF);
    run_req(0, 3'd2, 32'h0000_0100, 32'd0, 1);
    check("lw_rdata", rsp_rdata, 32'h80FF_7F01);

    run_req(0, 3'd2, 32'h0000_0102, 32'd0, 1);
    check("lw_mis_err", {31'd0, rsp_err}, 32'd1);
    run_req(0, 3'd1, 32'h0000_0101, 32'd0, 1);
    check("lh_mis_err", {31'd0, rsp_err}, 32'd1);
    run_req(1, 3'd3, 32'h0000_0100, 32'h5555_5555, 1);
    check("st_ill_err", {31'd0, rsp_err}, 32'd1);

    run_req(0, 3'd2, 32'h0000_0200, 32'd0, 9);
    check("to_err", {31'd0, rsp_err}, 32'd1);
    check("to_rdata", rsp_rdata, 32'd0);
    run_req(0, 3'd2, 32'h0000_0200, 32'd0, int'(TO));
    check("to_ack_err", {31'd0, rsp_err}, 32'd0);
    check("to_ack_rdata", rsp_rdata, 32'h80FF_7F01);

    // Reset in the middle of a BUSY access.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_f3 = 3'd2; req_addr = 32'h300; drv_lat = 9;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("rst_mid_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);

    stray_en = 1;
    repeat (8) @(negedge clk);
    check("stray_ready", {31'd0, req_ready}, 32'd1);
    fixed_rd = 0;

    // Randomized traffic with requests often held valid back-to-back.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 399) != 0);
      if (!req_valid || m_accepted) begin
        if ($urandom_range(0, 3) != 0) begin
          req_valid = 1;
          req_we    = $urandom_range(0, 1);
          req_f3    = 3'($urandom_range(0, 7));
          req_addr  = $urandom;
          if ($urandom_range(0, 1) == 0) req_addr[1:0] = 2'b00;
          req_wdata = $urandom;
          drv_lat   = $urandom_range(1, 6);
        end else begin
          req_valid = 0;
        end
      end
    end
    @(negedge clk);
    req_valid = 0;
    rst_n = 1;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
